// File: rtl/dsm_sample_ctrl_if.sv
// Signal bundle between an upstream sample source / controller and dsm_sample_ctrl.
// The master side drives samples and control; the slave side is the scheduler.
interface dsm_sample_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             enable;
   logic [WIDTH-1:0] s_data;
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] dac_data;
   logic             dac_load;
   logic [1:0]       state;
   logic             underrun;
   logic             underrun_clr;
   logic [7:0]       underrun_cnt;

   modport master (
      output enable, s_data, s_valid, underrun_clr,
      input  s_ready, dac_data, dac_load, state, underrun, underrun_cnt
   );

   modport slave (
      input  enable, s_data, s_valid, underrun_clr,
      output s_ready, dac_data, dac_load, state, underrun, underrun_cnt
   );
endinterface

// File: rtl/dsm_sample_ctrl.sv
// Single-clock sample scheduler for dsm_dac: one sample every OSR clocks, slew-limited
// start/stop ramps to/from midscale. Optional macro DSM_CTRL_UNDERRUN_CNT_EN adds the underrun counter.
module dsm_sample_ctrl #(
   parameter int               OSR       = 100,
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] MID       = {1'b1, {(WIDTH-1){1'b0}}},
   parameter logic [WIDTH-1:0] RAMP_STEP = WIDTH'(256)
) (
   input  logic              clk,
   input  logic              rst_n,
   dsm_sample_ctrl_if.slave  bus
);
   localparam int CW = (OSR > 2) ? $clog2(OSR) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, RAMP_UP = 2'd1, RUN = 2'd2, RAMP_DN = 2'd3} state_e;

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] buf_q, tgt_q, dac_q;
   logic             buf_full_q, load_q, und_q;

   logic             active, tick, s_ready, xfer, take, und_d;
   logic [WIDTH-1:0] tgt_d, up_d, dn_d;

   // One clamped slew step; never overshoots the destination.
   function automatic logic [WIDTH-1:0] toward(input logic [WIDTH-1:0] cur, input logic [WIDTH-1:0] dst);
      if (cur < dst) return (dst - cur <= RAMP_STEP) ? dst : cur + RAMP_STEP;
      else           return (cur - dst <= RAMP_STEP) ? dst : cur - RAMP_STEP;
   endfunction

   assign active  = (state_q == RAMP_UP) || (state_q == RUN);
   assign tick    = (state_q != IDLE) && (cnt_q == CW'(OSR - 1));
   assign s_ready = !buf_full_q && bus.enable && active;
   assign xfer    = bus.s_valid && s_ready;
   assign take    = tick && active && buf_full_q;
   assign und_d   = tick && active && !buf_full_q;
   assign tgt_d   = take ? buf_q : tgt_q;
   assign up_d    = toward(dac_q, tgt_d);
   assign dn_d    = toward(dac_q, MID);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         tgt_q      <= MID;
         dac_q      <= MID;
         load_q     <= 1'b0;
         und_q      <= 1'b0;
      end else begin
         load_q <= tick;
         cnt_q  <= (state_q == IDLE || tick) ? '0 : cnt_q + CW'(1);

         // xfer needs an empty buffer and take a full one, so they never collide.
         if (active && !bus.enable) buf_full_q <= 1'b0;
         else if (xfer)             buf_full_q <= 1'b1;
         else if (take)             buf_full_q <= 1'b0;
         if (xfer) buf_q <= bus.s_data;

         if (und_d)                 und_q <= 1'b1;
         else if (bus.underrun_clr) und_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (bus.enable) begin
                  state_q <= RAMP_UP;
                  tgt_q   <= MID;
               end
            end
            RAMP_DN: begin
               // Re-enable resumes from wherever the ramp-down currently sits.
               if (bus.enable) begin
                  state_q <= RAMP_UP;
                  tgt_q   <= dac_q;
               end else if (tick) begin
                  dac_q <= dn_d;
                  if (dn_d == MID) state_q <= IDLE;
               end
            end
            default: begin
               tgt_q <= tgt_d;
               if (tick) begin
                  dac_q <= (state_q == RUN) ? tgt_d : up_d;
                  if (state_q == RAMP_UP && up_d == tgt_d) state_q <= RUN;
               end
               if (!bus.enable) state_q <= RAMP_DN;
            end
         endcase
      end
   end

`ifdef DSM_CTRL_UNDERRUN_CNT_EN
   logic [7:0] ucnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ucnt_q <= '0;
      end else if (und_d) begin
         ucnt_q <= bus.underrun_clr ? 8'd1 : ((ucnt_q == 8'd255) ? 8'd255 : ucnt_q + 8'd1);
      end else if (bus.underrun_clr) begin
         ucnt_q <= '0;
      end
   end

   assign bus.underrun_cnt = ucnt_q;
`else
   assign bus.underrun_cnt = 8'd0;
`endif

   assign bus.s_ready  = s_ready;
   assign bus.dac_data = dac_q;
   assign bus.dac_load = load_q;
   assign bus.state    = state_q;
   assign bus.underrun = und_q;
endmodule

// File: tb/tb_dsm_sample_ctrl.sv
// Bench for dsm_sample_ctrl: directed scenarios plus random traffic, all checked each
// cycle against a tick-schedule reference model kept in absolute cycle numbers.
module tb_dsm_sample_ctrl;
   localparam int OSR  = 4;
   localparam int W    = 16;
   localparam int MID  = 'h8000;
   localparam int STEP = 'h1000;
`ifdef DSM_CTRL_UNDERRUN_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dsm_sample_ctrl_if #(.WIDTH(W)) bus ();

   dsm_sample_ctrl #(.OSR(OSR), .WIDTH(W), .MID(16'h8000), .RAMP_STEP(16'h1000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_pass = 0;

   // Reference model: mode 0 idle, 1 ramp up, 2 run, 3 ramp down.
   int cyc, m_mode, m_dac, m_tgt, m_tick_at, m_cnt;
   bit m_und, m_load;
   int m_buf[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic int toward(input int c, input int t);
      if (t > c) return (t - c > STEP) ? c + STEP : t;
      return (c - t > STEP) ? c - STEP : t;
   endfunction

   task automatic model_reset();
      cyc = 0; m_mode = 0; m_dac = MID; m_tgt = MID; m_tick_at = -1;
      m_cnt = 0; m_und = 0; m_load = 0;
      m_buf.delete();
   endtask

   task automatic model_edge(input bit en, input bit sv, input int sd, input bit clr, input bit rdy);
      bit is_tick, und_now;
      is_tick = (m_mode != 0) && (cyc == m_tick_at);
      und_now = 0;
      if (is_tick) m_tick_at = cyc + OSR;
      if (m_mode == 0) begin
         if (en) begin m_mode = 1; m_tgt = MID; m_tick_at = cyc + OSR; end
      end else if (m_mode == 3) begin
         if (en) begin m_mode = 1; m_tgt = m_dac; end
         else if (is_tick) begin
            m_dac = toward(m_dac, MID);
            if (m_dac == MID) m_mode = 0;
         end
      end else begin
         if (is_tick) begin
            if (m_buf.size() > 0) m_tgt = m_buf.pop_front();
            else und_now = 1;
            if (m_mode == 2) m_dac = m_tgt;
            else begin
               m_dac = toward(m_dac, m_tgt);
               if (m_dac == m_tgt) m_mode = 2;
            end
         end
         if (sv && rdy) m_buf.push_back(sd & 'hFFFF);
         if (!en) begin m_buf.delete(); m_mode = 3; end
      end
      if (und_now) begin
         m_und = 1;
         m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      end else if (clr) begin
         m_und = 0; m_cnt = 0;
      end
      m_load = is_tick;
      cyc++;
   endtask

   // Called just after a falling edge; leaves at the next falling edge.
   task automatic step(input bit en, input bit sv, input int sd, input bit clr);
      bit rdy;
      bus.enable = en; bus.s_valid = sv; bus.s_data = 16'(sd); bus.underrun_clr = clr;
      #1;
      rdy = (m_buf.size() == 0) && en && (m_mode == 1 || m_mode == 2);
      chk("s_ready", 32'(bus.s_ready), 32'(rdy));
      chk("dac_data", 32'(bus.dac_data), 32'(m_dac));
      chk("dac_load", 32'(bus.dac_load), 32'(m_load));
      chk("state", 32'(bus.state), 32'(m_mode));
      chk("underrun", 32'(bus.underrun), 32'(m_und));
      chk("underrun_cnt", 32'(bus.underrun_cnt), CNT_ON ? 32'(m_cnt) : 32'd0);
      model_edge(en, sv, sd, clr, rdy);
      @(negedge clk);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_dac"}, 32'(bus.dac_data), 32'h8000);
      chk({tag, "_load"}, 32'(bus.dac_load), 32'd0);
      chk({tag, "_state"}, 32'(bus.state), 32'd0);
      chk({tag, "_ready"}, 32'(bus.s_ready), 32'd0);
      chk({tag, "_und"}, 32'(bus.underrun), 32'd0);
      chk({tag, "_ucnt"}, 32'(bus.underrun_cnt), 32'd0);
   endtask

   initial begin
      int seen[$];
      bit found;
      int resets;
      bit en;
      bus.enable = 0; bus.s_valid = 0; bus.s_data = '0; bus.underrun_clr = 0;
      model_reset();
      repeat (3) @(negedge clk);
      reset_checks("reset");
      rst_n = 1'b1;

      // Idle with enable low stays parked at midscale.
      repeat (20) step(0, 0, 0, 0);
      reset_checks("idle20");

      // Ramp up to A000 in two slew steps.
      repeat (10) step(1, 1, 'hA000, 0);
      chk("rampup_state", 32'(bus.state), 32'd2);
      chk("rampup_dac", 32'(bus.dac_data), 32'hA000);

      // Upstream stall causes exactly one underrun; then clear it.
      repeat (8) step(1, 0, 'hA000, 0);
      chk("stall_dac", 32'(bus.dac_data), 32'hA000);
      chk("stall_und", 32'(bus.underrun), 32'd1);
      chk("stall_ucnt", 32'(bus.underrun_cnt), CNT_ON ? 32'd1 : 32'd0);
      step(1, 1, 'hC000, 1);
      chk("clr_und", 32'(bus.underrun), 32'd0);
      chk("clr_ucnt", 32'(bus.underrun_cnt), 32'd0);

      // RUN at C000, then disable and watch the staircase down to midscale.
      repeat (8) step(1, 1, 'hC000, 0);
      chk("run_c000", 32'(bus.dac_data), 32'hC000);
      step(0, 1, 'hC000, 0);
      chk("dis_ready", 32'(bus.s_ready), 32'd0);
      repeat (20) begin
         if (bus.dac_load && bus.dac_data != 16'hC000) seen.push_back(int'(bus.dac_data));
         step(0, 1, 'hC000, 0);
      end
      chk("rampdn_n", 32'(seen.size()), 32'd4);
      if (seen.size() == 4) begin
         chk("rampdn_0", 32'(seen[0]), 32'hB000);
         chk("rampdn_1", 32'(seen[1]), 32'hA000);
         chk("rampdn_2", 32'(seen[2]), 32'h9000);
         chk("rampdn_3", 32'(seen[3]), 32'h8000);
      end
      chk("rampdn_idle", 32'(bus.state), 32'd0);

      // Back up to C000, start ramping down, re-enable at A000.
      repeat (30) step(1, 1, 'hC000, 0);
      chk("rerun_c000", 32'(bus.dac_data), 32'hC000);
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (bus.dac_load && bus.state == 2'd3 && bus.dac_data == 16'hA000) found = 1;
         else step(0, 0, 0, 0);
      end
      chk("reach_a000", 32'(found), 32'd1);
      step(1, 1, 'h4000, 0);
      chk("reen_state", 32'(bus.state), 32'd1);
      chk("reen_dac", 32'(bus.dac_data), 32'hA000);
      repeat (4) step(1, 1, 'h4000, 0);
      chk("reen_step", 32'(bus.dac_data), 32'h9000);

      // Long starvation saturates the counter.
      repeat (300 * OSR + 8) step(1, 0, 0, 0);
      chk("sat_ucnt", 32'(bus.underrun_cnt), CNT_ON ? 32'd255 : 32'd0);
      chk("sat_und", 32'(bus.underrun), 32'd1);

      // Random traffic with occasional asynchronous reset while running.
      resets = 0;
      en = 1;
      for (int i = 0; i < 3000; i++) begin
         if (m_mode == 2 && resets < 3 && $urandom_range(0, 59) == 0) begin
            #2 rst_n = 1'b0;
            #1 reset_checks("midreset");
            model_reset();
            @(negedge clk);
            rst_n = 1'b1;
            resets++;
         end
         if ($urandom_range(0, 39) == 0) en = ~en;
         step(en, $urandom_range(0, 9) < 7, int'($urandom_range(0, 'hFFFF)), $urandom_range(0, 29) == 0);
      end
      chk("midreset_done", 32'(resets > 0), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/dsm_sample_ctrl.md
# dsm_sample_ctrl

Sample scheduler and sequencer in front of `dsm_dac`. It accepts PCM samples from an upstream source over a valid/ready handshake and presents one sample to the DAC every `OSR` system clocks. It replaces the free-running divided-clock source with a single-clock-domain strobe. It also sequences start/stop with a slew-limited ramp to and from midscale so that enabling or disabling the DAC causes no output step.

## Interface
- `OSR`, 100, system clocks per output sample (≥2).
- `WIDTH`, 16, sample width (offset binary, matches `dsm_in`).
- `MID`, 16'h8000, midscale / mute code.
- `RAMP_STEP`, 16'd256, maximum |change| of `dac_data` per sample tick during ramps (≥1).

Ports:
- `clk`  in  1  system clock (DSM clock).
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; 1 = play, 0 = return to midscale and idle.
- `s_data`  in  WIDTH  upstream sample.
- `s_valid`  in  1  upstream sample valid.
- `s_ready`  out  1  block can accept a sample this cycle.
- `dac_data`  out  WIDTH  drives `dsm_dac.dsm_in`.
- `dac_load`  out  1  one-cycle pulse coincident with each new `dac_data` value.
- `state`  out  2  IDLE=0, RAMP_UP=1, RUN=2, RAMP_DN=3.
- `underrun`  out  1  sticky underrun flag.
- `underrun_clr`  in  1  clears `underrun` (and the counter).
- `underrun_cnt`  out  8  saturating underrun count.

## Operation
- Reset values: `state`=IDLE, `dac_data`=MID, `dac_load`=0, `s_ready`=0, `underrun`=0, `underrun_cnt`=0, tick counter=0, buffer empty.
- Tick counter: counts 0..OSR-1 while `state`≠IDLE. "tick" is the cycle with count==OSR-1, and the counter wraps to 0 on that cycle. The counter is held at 0 in IDLE, so the first tick after leaving IDLE is OSR cycles later.
- One-entry buffer: `s_ready` = !buf_full && `enable` && `state`∈{RAMP_UP, RUN}. A transfer occurs when `s_valid`&&`s_ready`. `s_valid` with `s_ready`=0 is ignored; upstream holds it.
- On a tick, the decision uses registered buf_full at the start of that cycle:
  - buf_full=1: target←buffer, buffer emptied.
  - buf_full=0: underrun (RAMP_UP/RUN only). Target is unchanged, `underrun`←1, counter increments.
  - A transfer in the tick cycle of an empty buffer fills the buffer for the next tick. It still counts as an underrun.
- IDLE: `dac_data`=MID. On `enable`=1 → RAMP_UP, with target=MID.
- RAMP_UP, on each tick after the target update: if |target−dac_data| ≤ RAMP_STEP, dac_data←target and → RUN; otherwise dac_data moves RAMP_STEP toward target.
- RUN: each tick, dac_data←target.
- `enable`=0 in RAMP_UP or RUN → RAMP_DN (takes effect next cycle). The buffer is flushed and `s_ready`=0.
- RAMP_DN: each tick, dac_data steps toward MID by ≤RAMP_STEP. When it equals MID, → IDLE. No underruns are counted.
- `enable`=1 during RAMP_DN → RAMP_UP from the current dac_data, without returning to MID first.
- `dac_load`=1 on the cycle after every tick while `state`≠IDLE, even if the value is unchanged.
- `underrun_clr` clears the flag and counter. If it is coincident with a new underrun, the underrun wins: flag=1, count=1.
- Arithmetic is unsigned WIDTH bits with no wrap. Ramp steps are clamped so the value never overshoots target or MID.

## Timing
- Registered outputs: `dac_data`, `dac_load`, `state`, `underrun`, `underrun_cnt`.
- `s_ready` is combinational from registered state/buffer and `enable`.
- Sample latency: a sample in the buffer at a tick appears on `dac_data` 1 cycle after that tick (RUN).
- Output sample period is exactly OSR clocks, with no jitter.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). The first post-reset tick follows enable by OSR cycles.

## Configuration
- `DSM_CTRL_UNDERRUN_CNT_EN` defined: the 8-bit saturating counter is implemented and stops at 255.
- Not defined: the counter logic is removed and `underrun_cnt` is tied to 8'd0. The `underrun` flag is unaffected.

## Test plan
All scenarios use OSR=4, RAMP_STEP=16'h1000.
- Reset, enable=0, 20 cycles → dac_data=16'h8000, dac_load=0, state=IDLE, s_ready=0.
- Enable with s_valid held and s_data=16'hA000 → dac_data takes 16'h9000 then 16'hA000 on consecutive ticks 4 cycles apart. state=RUN after the second step. dac_load pulses every 4 cycles.
- RUN, upstream stalls one tick → dac_data repeats the previous value, underrun=1, underrun_cnt=1. Then pulse underrun_clr → flag=0, count=0.
- RUN at 16'hC000, enable→0 → s_ready=0 next cycle. dac_data takes C000→B000→A000→9000→8000 on ticks, then state=IDLE.
- During RAMP_DN at 16'hA000, enable→1 → state=RAMP_UP, ramping from 16'hA000 toward the next sample.
- 300 consecutive underruns → underrun_cnt=255 with the macro defined, 0 without it.
- Assert rst_n low mid-RUN → all outputs are at reset values before the next clock edge.
